// File: rtl/div_share_arbiter.sv
// Round-robin arbiter sharing one iterative divider core among NREQ requesters.
// Optional DIV_ARB_ZERO_BYPASS_EN: zero divisors are answered locally without starting the core.
module div_share_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_dividend,
  input  logic [NREQ*W-1:0] req_divisor,
  output logic [NREQ-1:0]   resp_valid,
  input  logic [NREQ-1:0]   resp_ready,
  output logic [W-1:0]      resp_quotient,
  output logic [W-1:0]      resp_remainder,
  output logic              resp_dz,
  output logic              div_start,
  output logic [W-1:0]      div_dividend,
  output logic [W-1:0]      div_divisor,
  input  logic [W-1:0]      div_quotient,
  input  logic [W-1:0]      div_remainder,
  input  logic              div_done
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] grant_q, grant_d, grant_c;
  logic          any_valid;
  logic [W-1:0]  opa_q, opa_d, opb_q, opb_d;
  logic [W-1:0]  quot_q, quot_d, rem_q, rem_d;
`ifdef DIV_ARB_ZERO_BYPASS_EN
  logic          dz_q, dz_d;
`endif

  // Priority search starting at rr_ptr; descending k so the closest valid wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant_c   = rr_ptr_q;
    any_valid = 1'b0;
    for (int k = NREQ-1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_valid[idx]) begin
        grant_c   = IW'(idx);
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
`ifdef DIV_ARB_ZERO_BYPASS_EN
    dz_d       = dz_q;
`endif
    req_ready  = '0;
    resp_valid = '0;
    div_start  = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          req_ready[grant_c] = 1'b1;
          grant_d = grant_c;
          opa_d   = req_dividend[int'(grant_c)*W +: W];
          opb_d   = req_divisor[int'(grant_c)*W +: W];
`ifdef DIV_ARB_ZERO_BYPASS_EN
          dz_d    = 1'b0;
`endif
          state_d = ISSUE;
        end
      end
      ISSUE: begin
`ifdef DIV_ARB_ZERO_BYPASS_EN
        if (opb_q == '0) begin
          quot_d  = '1;
          rem_d   = opa_q;
          dz_d    = 1'b1;
          state_d = RESP;
        end else begin
          div_start = 1'b1;
          state_d   = WAIT;
        end
`else
        div_start = 1'b1;
        state_d   = WAIT;
`endif
      end
      WAIT: begin
        if (div_done) begin
          quot_d  = div_quotient;
          rem_d   = div_remainder;
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid[grant_q] = 1'b1;
        if (resp_ready[grant_q]) begin
          rr_ptr_d = (grant_q == IW'(NREQ-1)) ? '0 : grant_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
`ifdef DIV_ARB_ZERO_BYPASS_EN
      dz_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
`ifdef DIV_ARB_ZERO_BYPASS_EN
      dz_q     <= dz_d;
`endif
    end
  end

  assign div_dividend   = opa_q;
  assign div_divisor    = opb_q;
  assign resp_quotient  = quot_q;
  assign resp_remainder = rem_q;
`ifdef DIV_ARB_ZERO_BYPASS_EN
  assign resp_dz        = dz_q;
`else
  assign resp_dz        = 1'b0;
`endif

endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter with a latency-programmable divider model
// and a scoreboard of expected responses filled at each accepted request.
module tb_div_share_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid, req_ready, resp_valid, resp_ready;
  logic [NREQ*W-1:0] req_dividend, req_divisor;
  logic [W-1:0]      resp_quotient, resp_remainder, div_dividend, div_divisor;
  logic [W-1:0]      div_quotient, div_remainder;
  logic              resp_dz, div_start, div_done;

  logic              core_done = 1'b0, stray_done = 1'b0;
  logic [W-1:0]      core_q = '0, core_r = '0;
  int                core_cnt = 0;
  int                lat = 32;

  typedef struct {int id; logic [W-1:0] q; logic [W-1:0] r; logic dz;} exp_t;
  exp_t sb[$];
  int   grant_log[$];
  int   acc_log[$];

  int n_tests = 0, n_fail = 0;
  int cyc = 0, n_acc = 0, n_resp = 0, start_cnt = 0;
  int acc_cyc = 0, start_cyc = 0, resp_cyc = 0, hs_cyc = 0;
  bit resp_seen = 0;

  assign div_done      = core_done | stray_done;
  assign div_quotient  = stray_done ? 32'hDEAD_BEEF : core_q;
  assign div_remainder = stray_done ? 32'hBAAD_F00D : core_r;

  always #5 clk = ~clk;

  div_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_quotient(resp_quotient), .resp_remainder(resp_remainder), .resp_dz(resp_dz),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .div_done(div_done)
  );

  // Divider model: done pulses exactly lat cycles after the start cycle.
  always @(posedge clk) begin
    #1;
    core_done = 1'b0;
    if (core_cnt > 0) begin
      core_cnt = core_cnt - 1;
      if (core_cnt == 0) begin
        core_done = 1'b1;
        core_q = (div_divisor == '0) ? '1 : div_dividend / div_divisor;
        core_r = (div_divisor == '0) ? div_dividend : div_dividend % div_divisor;
      end
    end
    if (div_start === 1'b1) core_cnt = lat;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: sample just before the rising edge, then advance to the falling edge.
  task automatic step();
    exp_t e, g;
    int id;
    logic [W-1:0] a, b;
    #4;
    if (req_ready !== '0) begin
      check("rdy_onehot", 64'($onehot(req_ready)), 64'd1);
      id = 0;
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) id = i;
      a = req_dividend[id*W +: W];
      b = req_divisor[id*W +: W];
      e.id = id;
      e.q  = (b == '0) ? '1 : a / b;
      e.r  = (b == '0) ? a : a % b;
`ifdef DIV_ARB_ZERO_BYPASS_EN
      e.dz = (b == '0);
`else
      e.dz = 1'b0;
`endif
      sb.push_back(e);
      grant_log.push_back(id);
      acc_log.push_back(cyc);
      acc_cyc = cyc;
      n_acc++;
    end
    if (div_start === 1'b1) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (resp_valid !== '0 && !resp_seen) begin
      resp_seen = 1;
      resp_cyc  = cyc;
    end
    if ((resp_valid & resp_ready) != '0) begin
      if (sb.size() == 0) begin
        check("sb_empty", 64'd1, 64'd0);
      end else begin
        g = sb.pop_front();
        check("resp_owner", 64'(resp_valid), 64'(1 << g.id));
        check("resp_q", 64'(resp_quotient), 64'(g.q));
        check("resp_r", 64'(resp_remainder), 64'(g.r));
        check("resp_dz", 64'(resp_dz), 64'(g.dz));
      end
      resp_seen = 0;
      hs_cyc = cyc;
      n_resp++;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_acc(input int target, input int budget);
    int n;
    n = 0;
    while (n_acc < target && n < budget) begin step(); n++; end
    if (n_acc < target) check("accept_timeout", 64'(n_acc), 64'(target));
  endtask

  task automatic wait_resp(input int target, input int budget);
    int n;
    n = 0;
    while (n_resp < target && n < budget) begin step(); n++; end
    if (n_resp < target) check("resp_timeout", 64'(n_resp), 64'(target));
  endtask

  task automatic wait_rv(input int budget);
    int n;
    n = 0;
    while (resp_valid === '0 && n < budget) begin step(); n++; end
    check("rv_timeout", 64'(resp_valid !== '0), 64'd1);
  endtask

  task automatic set_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[id] = 1'b1;
    req_dividend[id*W +: W] = a;
    req_divisor[id*W +: W]  = b;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    resp_seen = 0;
  endtask

  initial begin
    int base, sc;
    bit saw_rv;
    logic [W-1:0] q_hold;
    reset = 1'b1;
    req_valid = '0; resp_ready = '0;
    req_dividend = '0; req_divisor = '0;

    // Reset values
    @(negedge clk);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_div_start", 64'(div_start), 64'd0);
    check("rst_opa", 64'(div_dividend), 64'd0);
    check("rst_opb", 64'(div_divisor), 64'd0);
    check("rst_q", 64'(resp_quotient), 64'd0);
    check("rst_r", 64'(resp_remainder), 64'd0);
    check("rst_dz", 64'(resp_dz), 64'd0);
    reset = 1'b0;
    step();

    // Single request 50/2, L=32
    lat = 32;
    resp_ready = 4'b0001;
    set_req(0, 50, 2);
    wait_acc(1, 20);
    req_valid = '0;
    wait_resp(1, 60);
    check("lat_start", 64'(start_cyc - acc_cyc), 64'd1);
    check("lat_resp", 64'(resp_cyc - acc_cyc), 64'd34);

    // All requesters valid, resp_ready high: grant order from rr_ptr=0
    do_reset();
    lat = 4;
    resp_ready = '1;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(20 + 10*i), 32'(i + 3));
    base = grant_log.size();
    wait_acc(n_acc + 5, 60);
    req_valid = '0;
    check("rr_g0", 64'(grant_log[base+0]), 64'd0);
    check("rr_g1", 64'(grant_log[base+1]), 64'd1);
    check("rr_g2", 64'(grant_log[base+2]), 64'd2);
    check("rr_g3", 64'(grant_log[base+3]), 64'd3);
    check("rr_g4", 64'(grant_log[base+4]), 64'd0);
    check("throughput", 64'(acc_log[base+1] - acc_log[base+0]), 64'(lat + 3));
    wait_resp(n_acc, 30);

    // Response withheld: 100/7 on requester 2
    lat = 8;
    resp_ready = '0;
    set_req(2, 100, 7);
    wait_acc(n_acc + 1, 20);
    req_valid = '0;
    set_req(0, 11, 3);
    resp_ready = 4'b1011;
    wait_rv(30);
    for (int i = 0; i < 10; i++) begin
      check("hold_rv", 64'(resp_valid), 64'b0100);
      check("hold_q", 64'(resp_quotient), 64'd14);
      check("hold_r", 64'(resp_remainder), 64'd2);
      check("hold_rdy", 64'(req_ready), 64'd0);
      step();
    end
    resp_ready = '1;
    wait_acc(n_acc + 1, 20);
    req_valid = '0;
    check("next_acc", 64'(acc_cyc - hs_cyc), 64'd1);
    check("next_grant", 64'(grant_log[grant_log.size()-1]), 64'd0);
    wait_resp(n_acc, 30);

    // Reset in WAIT, late div_done must be ignored
    lat = 20;
    set_req(1, 60, 5);
    wait_acc(n_acc + 1, 20);
    req_valid = '0;
    repeat (5) step();
    reset = 1'b1;
    #1;
    check("mid_rst_rv", 64'(resp_valid), 64'd0);
    check("mid_rst_opa", 64'(div_dividend), 64'd0);
    check("mid_rst_q", 64'(resp_quotient), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    resp_seen = 0;
    saw_rv = 0;
    for (int i = 0; i < 25; i++) begin
      if (resp_valid !== '0) saw_rv = 1;
      step();
    end
    check("late_done_ignored", 64'(saw_rv), 64'd0);
    set_req(1, 45, 6);
    set_req(3, 8, 2);
    wait_acc(n_acc + 1, 20);
    req_valid = '0;
    check("post_rst_grant", 64'(grant_log[grant_log.size()-1]), 64'd1);
    wait_resp(n_resp + 1, 40);

    // Divide by zero: 9/0
    lat = 6;
    sc = start_cnt;
    set_req(0, 9, 0);
    wait_acc(n_acc + 1, 20);
    req_valid = '0;
    wait_resp(n_resp + 1, 30);
`ifdef DIV_ARB_ZERO_BYPASS_EN
    check("dz_starts", 64'(start_cnt - sc), 64'd0);
    check("dz_lat", 64'(resp_cyc - acc_cyc), 64'd2);
`else
    check("dz_starts", 64'(start_cnt - sc), 64'd1);
    check("dz_lat", 64'(resp_cyc - acc_cyc), 64'(lat + 2));
`endif

    // Stray div_done in IDLE and in RESP
    sc = start_cnt;
    stray_done = 1'b1;
    step();
    stray_done = 1'b0;
    step();
    check("stray_idle_q", 64'(resp_quotient), 64'hFFFF_FFFF);
    check("stray_idle_r", 64'(resp_remainder), 64'd9);
    check("stray_idle_rv", 64'(resp_valid), 64'd0);
    check("stray_idle_start", 64'(start_cnt - sc), 64'd0);
    resp_ready = '0;
    set_req(1, 30, 4);
    wait_acc(n_acc + 1, 20);
    req_valid = '0;
    wait_rv(30);
    q_hold = resp_quotient;
    stray_done = 1'b1;
    step();
    stray_done = 1'b0;
    step();
    check("stray_resp_q", 64'(resp_quotient), 64'd7);
    check("stray_resp_r", 64'(resp_remainder), 64'd2);
    check("stray_resp_rv", 64'(resp_valid), 64'b0010);
    check("stray_resp_stable", 64'(resp_quotient), 64'(q_hold));
    resp_ready = '1;
    wait_resp(n_resp + 1, 10);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
